// File: rtl/nes_pkg.sv
// Shared NES bus definitions: DMA state encoding and the register addresses
// used by both the OAM DMA arbiter and the PPU register decoder.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_REG_ADDR = 16'h2004;
  localparam int          OAM_XFER_LEN      = 256;

  // Index width for a transfer length; never narrower than one bit.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-map-side signals of the OAM DMA arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic        cpu_ready;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        busy;

  modport slave (
    input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    output cpu_ready, bus_addr, bus_d_out, bus_write, busy
  );

  modport master (
    output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    input  cpu_ready, bus_addr, bus_d_out, bus_write, busy
  );
endinterface

// File: rtl/oam_dma_arbiter_bus_mux.sv
// Combinational bus owner select: the CPU drives the memory map unless a DMA
// transfer is in progress.
module oam_dma_arbiter_bus_mux (
  input  logic        sel_dma,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_d_out,
  input  logic        dma_write,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write
);

  always_comb begin
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_write = cpu_write;
    if (sel_dma) begin
      bus_addr  = dma_addr;
      bus_d_out = dma_d_out;
      bus_write = dma_write;
    end
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Sprite OAM DMA: a CPU write to DMA_REG_ADDR stalls the CPU and copies one
// page to OAM_DATA_ADDR. Define OAM_DMA_ODD_ALIGN_EN to align reads to even cycles.
module oam_dma_arbiter
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_REG_ADDR,
  parameter int          XFER_LEN      = OAM_XFER_LEN
) (
  input  logic            clk,
  input  logic            reset,
  oam_dma_arbiter_if.slave sys
);

  localparam int IDX_W = idx_width(XFER_LEN);

  dma_state_t       state_reg, state_next;
  logic [7:0]       page_reg, page_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       data_reg, data_next;

  logic [15:0] dma_addr;
  logic [7:0]  dma_d_out;
  logic        dma_write;
  logic        trigger;
  logic        dma_busy;

  assign trigger = sys.cpu_write && (sys.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      page_reg  <= 8'h00;
      idx_reg   <= '0;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
    end
  end

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic cyc_odd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_odd_reg <= 1'b0;
    end else begin
      cyc_odd_reg <= ~cyc_odd_reg;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    dma_addr   = {page_reg, 8'h00};
    dma_d_out  = data_reg;
    dma_write  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          page_next  = sys.cpu_d_out;
          idx_next   = '0;
          state_next = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
        // An even HALT cycle would put the first read on an odd cycle.
        state_next = cyc_odd_reg ? READ : ALIGN;
`else
        state_next = READ;
`endif
      end
      ALIGN: begin
        state_next = READ;
      end
      READ: begin
        dma_addr   = {page_reg, 8'(idx_reg)};
        data_next  = sys.bus_d_in;
        state_next = WRITE;
      end
      WRITE: begin
        dma_addr  = OAM_DATA_ADDR;
        dma_write = 1'b1;
        // idx wraps naturally; the page is never carried into.
        idx_next  = idx_reg + 1'b1;
        if (idx_reg == IDX_W'(XFER_LEN - 1)) begin
          state_next = IDLE;
        end else begin
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dma_busy      = (state_reg != IDLE);
  assign sys.busy      = dma_busy;
  assign sys.cpu_ready = ~dma_busy;

  oam_dma_arbiter_bus_mux u_bus_mux (
    .sel_dma   (dma_busy),
    .cpu_addr  (sys.cpu_addr),
    .cpu_d_out (sys.cpu_d_out),
    .cpu_write (sys.cpu_write),
    .dma_addr  (dma_addr),
    .dma_d_out (dma_d_out),
    .dma_write (dma_write),
    .bus_addr  (sys.bus_addr),
    .bus_d_out (sys.bus_d_out),
    .bus_write (sys.bus_write)
  );

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: passthrough vectors, full page
// transfers against a memory model, page FF wrap and reset mid-transfer.
module tb_oam_dma_arbiter;
  import nes_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_arbiter_if dif ();

  oam_dma_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .sys   (dif.slave)
  );

  logic [7:0] mem [65536];
  assign dif.bus_d_in = mem[dif.bus_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle parity model: first cycle after reset has index 0 (even).
  int unsigned cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] rd_addr;
    logic [7:0]  data;
  } xfer_t;
  xfer_t       sb[$];
  logic [7:0]  cur_page = 8'h00;
  logic [15:0] last_rd  = 16'h0000;
  int          wr_count = 0;

  // Bus monitor: DMA reads must stay in the page, each $2004 write must carry
  // the byte read in the preceding read cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (dif.busy) begin
        if (!dif.bus_write) begin
          last_rd = dif.bus_addr;
          check("rd_page", 32'(dif.bus_addr[15:8]), 32'(cur_page));
        end else begin
          check("wr_addr", 32'(dif.bus_addr), 32'(OAM_DATA_REG_ADDR));
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_wr: got data %h expected no write", dif.bus_d_out);
          end else begin
            xfer_t e;
            e = sb.pop_front();
            check("rd_addr", 32'(last_rd), 32'(e.rd_addr));
            check("wr_data", 32'(dif.bus_d_out), 32'(e.data));
          end
`ifdef OAM_DMA_ODD_ALIGN_EN
          check("rd_even", 32'(cyc[0]), 32'd1);
`endif
          wr_count++;
        end
      end else begin
        check("idle_wr", 32'(dif.bus_write), 32'(dif.cpu_write));
      end
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        wr;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;
    logic        exp_wr;
    logic        exp_ready;
    logic        exp_busy;
  } vec_t;

  task automatic cpu_idle();
    dif.cpu_addr  = 16'h8000;
    dif.cpu_d_out = 8'h00;
    dif.cpu_write = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] page, output int unsigned trig_cyc);
    @(posedge clk);
    #1;
    dif.cpu_addr  = OAM_DMA_REG_ADDR;
    dif.cpu_d_out = page;
    dif.cpu_write = 1'b1;
    trig_cyc      = cyc;
    cur_page      = page;
    for (int i = 0; i < 256; i++) begin
      xfer_t e;
      e.rd_addr = {page, 8'(i)};
      e.data    = mem[{page, 8'(i)}];
      sb.push_back(e);
    end
    @(negedge clk);
    check("trig_pass_addr", 32'(dif.bus_addr), 32'(OAM_DMA_REG_ADDR));
    check("trig_pass_wr", 32'(dif.bus_write), 32'd1);
    check("trig_ready", 32'(dif.cpu_ready), 32'd1);
    @(posedge clk);
    #1;
    cpu_idle();
  endtask

  task automatic run_dma(input logic [7:0] page);
    int unsigned trig_cyc;
    int stall;
    int exp_stall;
    start_dma(page, trig_cyc);
    stall = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!dif.cpu_ready) stall++;
      else break;
    end
`ifdef OAM_DMA_ODD_ALIGN_EN
    // HALT runs the cycle after the trigger; an even HALT needs the ALIGN pad.
    exp_stall = trig_cyc[0] ? 514 : 513;
`else
    exp_stall = 513;
`endif
    check("stall_len", 32'(stall), 32'(exp_stall));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("busy_end", 32'(dif.busy), 32'd0);
    $display("dma page=%h trig_cyc=%0d stall=%0d expected=%0d last_rd=%h",
             page, trig_cyc, stall, exp_stall, last_rd);
    sb.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int base;
    int unsigned tc;
    bit hit;

    vecs[0] = '{16'h0200, 8'h5A, 1'b1, 16'h0200, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{16'h4014, 8'h33, 1'b0, 16'h4014, 8'h33, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h4015, 8'h77, 1'b1, 16'h4015, 8'h77, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h4013, 8'h11, 1'b1, 16'h4013, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h2004, 8'hC3, 1'b1, 16'h2004, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFC, 8'h00, 1'b0, 16'hFFFC, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 8'h00, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b1, 1'b0};

    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av     = 16'(a);
      mem[a] = av[7:0] ^ 8'hA5 ^ (av[15:8] - 8'h03);
    end

    reset = 1'b1;
    cpu_idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(dif.cpu_ready), 32'd1);
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_pass_addr", 32'(dif.bus_addr), 32'h8000);
    $display("reset ready=%b busy=%b", dif.cpu_ready, dif.busy);

    // Passthrough and non-trigger accesses, including a read of the DMA register.
    for (int v = 0; v < 7; v++) begin
      @(posedge clk);
      #1;
      dif.cpu_addr  = vecs[v].addr;
      dif.cpu_d_out = vecs[v].dout;
      dif.cpu_write = vecs[v].wr;
      @(negedge clk);
      check("vec_addr", 32'(dif.bus_addr), 32'(vecs[v].exp_addr));
      check("vec_dout", 32'(dif.bus_d_out), 32'(vecs[v].exp_dout));
      check("vec_wr", 32'(dif.bus_write), 32'(vecs[v].exp_wr));
      check("vec_ready", 32'(dif.cpu_ready), 32'(vecs[v].exp_ready));
      check("vec_busy", 32'(dif.busy), 32'(vecs[v].exp_busy));
      $display("vec %0d addr=%h wr=%b bus_addr=%h bus_wr=%b ready=%b busy=%b",
               v, vecs[v].addr, vecs[v].wr, dif.bus_addr, dif.bus_write,
               dif.cpu_ready, dif.busy);
    end
    @(posedge clk);
    #1;
    cpu_idle();

    run_dma(8'h03);

    // Reset after the 100th $2004 write.
    base = wr_count;
    start_dma(8'h03, tc);
    hit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (wr_count >= base + 100) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_100_wr", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    base = wr_count;
    @(negedge clk);
    check("midrst_ready", 32'(dif.cpu_ready), 32'd1);
    check("midrst_busy", 32'(dif.busy), 32'd0);
    repeat (20) @(negedge clk);
    check("midrst_no_wr", 32'(wr_count - base), 32'd0);
    $display("mid-transfer reset ready=%b busy=%b writes_after=%0d",
             dif.cpu_ready, dif.busy, wr_count - base);

    run_dma(8'h03);

    run_dma(8'hFF);
    check("wrap_last_rd", 32'(last_rd), 32'h0000FFFF);

    // Opposite trigger parity, and index restarting at 0 after the wrap.
    @(posedge clk);
    run_dma(8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
